// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store initiator for the byte-addressable memory block.
//
// Takes one load or store at a time from the memory stage over a valid/ready
// handshake. Sub-word stores become read-modify-write, because the memory
// always writes four bytes. Load data is sign- or zero-extended, and each
// request gets exactly one single-cycle response pulse.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_addr_i               byte address
//   req_wdata_i              store data, low-aligned
//   req_we_i                 1 = store, 0 = load
//   req_funct3_i             RV32I width/sign code
//   rsp_valid_o              one-cycle response pulse
//   rsp_rdata_o, rsp_err_o   registered response payload, held until next response
//   mem_addr_o, mem_data_o   address/write data to memory (0 when not enabled)
//   mem_read_en_o            memory read strobe (RD state)
//   mem_write_en_o           memory write strobe (WR state)
//   mem_data_i               read data from memory
//   mem_data_vld_i           read data valid from memory
//
// Configuration macro: LSU_ALIGN_CHECK_EN. When it is defined, misaligned
// halfword and word requests are rejected with an error response and no
// memory access. When it is undefined, those requests go to memory as-is.

module lsu_mem_port #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              mem_data_vld_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [DWIDTH-1:0] rbuf_q;
    logic [CW-1:0]     wait_q;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_load;
    logic              legal, misaligned;

    // Legal codes: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
    assign legal = req_we_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                            : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef LSU_ALIGN_CHECK_EN
    // funct3[1:0] is 01 for halfwords and 10 for words. Illegal codes that
    // share those bits have already been rejected by the legal check.
    assign misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // The memory returns bytes addr..addr+3 in [7:0]..[31:24], so the low
    // bytes are always the addressed ones and no lane shifting is needed.
    function automatic logic [DWIDTH-1:0] extend(input logic [2:0] f3, input logic [DWIDTH-1:0] d);
        case (f3)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'b0, d[7:0]};
            3'b101:  extend = {16'b0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic [DWIDTH-1:0] merge(input logic [2:0] f3, input logic [DWIDTH-1:0] rb,
                                                input logic [DWIDTH-1:0] wd);
        case (f3[1:0])
            2'b00:   merge = {rb[31:8], wd[7:0]};
            2'b01:   merge = {rb[31:16], wd[15:0]};
            default: merge = wd;
        endcase
    endfunction

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves a value held and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        rsp_load    = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (!legal || misaligned) begin
                        state_d   = RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end else if (req_we_i && req_funct3_i == 3'b010) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;   // loads, plus SB/SH for read-modify-write
                    end
                end
            end
            RD: begin
                if (mem_data_vld_i) begin
                    if (we_q) begin
                        state_d = WR;
                    end else begin
                        state_d     = RESP;
                        rsp_load    = 1'b1;
                        rsp_rdata_d = extend(funct3_q, mem_data_i);
                    end
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            WR: begin
                state_d  = RESP;
                rsp_load = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            rbuf_q      <= '0;
            wait_q      <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
            end
            if (state_q == RD) begin
                if (mem_data_vld_i) begin
                    rbuf_q <= mem_data_i;
                    wait_q <= '0;
                end else begin
                    wait_q <= wait_q + 1'b1;
                end
            end else begin
                wait_q <= '0;
            end
            if (rsp_load) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
        end
    end

    // Outputs are also gated by rst. The reset cycle itself therefore
    // shows no handshake, no memory strobe and no response, whatever state
    // the FSM was in before the reset.
    assign req_ready_o    = (state_q == IDLE) && !rst;
    assign rsp_valid_o    = (state_q == RESP) && !rst;
    assign rsp_rdata_o    = rst ? '0 : rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q && !rst;
    assign mem_read_en_o  = (state_q == RD) && !rst;
    assign mem_write_en_o = (state_q == WR) && !rst;
    assign mem_addr_o     = (mem_read_en_o || mem_write_en_o) ? addr_q : '0;
    assign mem_data_o     = mem_write_en_o ? merge(funct3_q, rbuf_q, wdata_q) : '0;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed testbench for lsu_mem_port. A byte-array memory model answers
// reads in the same cycle they are issued and records every write. Each
// request pushes its expected response into a scoreboard queue; the entry is
// popped when rsp_valid_o appears and compared with the observed response.

module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i = '0;
    logic        mem_data_vld_i = 1'b0;

    lsu_mem_port #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_we_i       (req_we_i),
        .req_funct3_i   (req_funct3_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_data_i     (mem_data_i),
        .mem_data_vld_i (mem_data_vld_i)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Memory model. It updates 1 time unit after each rising edge, so it
    // sees the DUT outputs of the current cycle and answers before the next edge.
    bit [7:0]    mem_b [bit [31:0]];
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, wr_cyc = 0;
    logic [31:0] wr_data = '0, wr_addr = '0;
    bit          vld_en = 1'b1;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = mem_b.exists(a + 32'(i)) ? mem_b[a + 32'(i)] : 8'h00;
        return w;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_write_en_o === 1'b1) begin
            put_word(mem_addr_o, mem_data_o);
            wr_cnt++;
            wr_cyc  = cyc;
            wr_data = mem_data_o;
            wr_addr = mem_addr_o;
        end
        if (mem_read_en_o === 1'b1) begin
            rd_cnt++;
            mem_data_i     = rd_word(mem_addr_o);
            mem_data_vld_i = vld_en;
        end else begin
            mem_data_i     = '0;
            mem_data_vld_i = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of an IDLE cycle (cycle T). It drives the
    // request for one edge, waits for the response and checks it, then
    // returns at the falling edge of the cycle after the response.
    task automatic do_req(input string tag, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat,
                          input int exp_rd, input int exp_wr_lat, input logic [31:0] exp_wr_data);
        int          c0, wr0, rd0, lat;
        bit          got;
        logic [31:0] o_rdata;
        logic        o_err;
        exp_t        e;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat});
        chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
        c0 = cyc; wr0 = wr_cnt; rd0 = rd_cnt;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wdata;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        got = 1'b0; lat = 0; o_rdata = '0; o_err = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                got = 1'b1;
                lat = cyc - c0;
                o_rdata = rsp_rdata_o;
                o_err = rsp_err_o;
            end
        end
        chk({tag, " rsp seen"}, 32'(got), 32'd1);
        if (got) begin
            e = sb_q.pop_front();
            chk({tag, " latency"}, 32'(lat), 32'(e.lat));
            chk({tag, " rdata"}, o_rdata, e.rdata);
            chk({tag, " err"}, 32'(o_err), 32'(e.err));
        end
        chk({tag, " read cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        if (exp_wr_lat < 0) begin
            chk({tag, " writes"}, 32'(wr_cnt - wr0), 32'd0);
        end else begin
            chk({tag, " writes"}, 32'(wr_cnt - wr0), 32'd1);
            chk({tag, " write cycle"}, 32'(wr_cyc - c0), 32'(exp_wr_lat));
            chk({tag, " write data"}, wr_data, exp_wr_data);
            chk({tag, " write addr"}, wr_addr, addr);
        end
        @(negedge clk);
    endtask

    initial begin
        int wr0, seen;
        put_word(32'h0100_0000, 32'h0000_9ABC);
        put_word(32'h0100_0004, 32'h1234_5680);
        put_word(32'h0100_0008, 32'h1122_3344);
        put_word(32'h0100_000C, 32'hAAAA_AAAA);

        // Initial reset
        repeat (2) begin
            @(negedge clk);
            chk("reset ready", 32'(req_ready_o), 32'd0);
            chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("reset rd_en", 32'(mem_read_en_o), 32'd0);
            chk("reset wr_en", 32'(mem_write_en_o), 32'd0);
            chk("reset rdata", rsp_rdata_o, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Load extension on 0x12345680 and 0x00009ABC
        do_req("LB",  0, F_B,  32'h0100_0004, 0, 32'hFFFF_FF80, 0, 2, 1, -1, 0);
        do_req("LBU", 0, F_BU, 32'h0100_0004, 0, 32'h0000_0080, 0, 2, 1, -1, 0);
        do_req("LH",  0, F_H,  32'h0100_0004, 0, 32'h0000_5680, 0, 2, 1, -1, 0);
        do_req("LHU", 0, F_HU, 32'h0100_0006, 0, 32'h0000_1234, 0, 2, 1, -1, 0);
        do_req("LHn", 0, F_H,  32'h0100_0000, 0, 32'hFFFF_9ABC, 0, 2, 1, -1, 0);
        do_req("LHUn",0, F_HU, 32'h0100_0000, 0, 32'h0000_9ABC, 0, 2, 1, -1, 0);
        do_req("LW",  0, F_W,  32'h0100_0004, 0, 32'h1234_5680, 0, 2, 1, -1, 0);

        // Stores: SB/SH read-modify-write, SW direct
        do_req("SB",   1, F_B, 32'h0100_0008, 32'hDEAD_BEAB, 0, 0, 3, 1, 2, 32'h1122_33AB);
        do_req("LW SB",0, F_W, 32'h0100_0008, 0, 32'h1122_33AB, 0, 2, 1, -1, 0);
        do_req("SH",   1, F_H, 32'h0100_000C, 32'h0000_BEEF, 0, 0, 3, 1, 2, 32'hAAAA_BEEF);
        do_req("SW",   1, F_W, 32'h0100_0010, 32'hCAFE_F00D, 0, 0, 2, 0, 1, 32'hCAFE_F00D);
        do_req("LW SW",0, F_W, 32'h0100_0010, 0, 32'hCAFE_F00D, 0, 2, 1, -1, 0);

        // Response payload holds while idle
        repeat (3) @(negedge clk);
        chk("hold rdata", rsp_rdata_o, 32'hCAFE_F00D);
        chk("hold valid", 32'(rsp_valid_o), 32'd0);

        // Illegal funct3 codes
        do_req("ILL ld", 0, 3'b011, 32'h0100_0004, 0, 0, 1, 1, 0, -1, 0);
        do_req("ILL st", 1, 3'b100, 32'h0100_0004, 32'h1, 0, 1, 1, 0, -1, 0);

        // Read timeout: memory never answers
        vld_en = 1'b0;
        do_req("TIMEOUT", 0, F_W, 32'h0100_0004, 0, 0, 1, 17, 16, -1, 0);
        vld_en = 1'b1;

        // Misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
        do_req("LW mis", 0, F_W, 32'h0100_0002, 0, 0, 1, 1, 0, -1, 0);
`else
        do_req("LW mis", 0, F_W, 32'h0100_0002, 0, 32'h5680_0000, 0, 2, 1, -1, 0);
`endif
        do_req("LW pre", 0, F_W, 32'h0100_0004, 0, 32'h1234_5680, 0, 2, 1, -1, 0);

        // Reset while an SB waits in RD
        vld_en = 1'b0;
        wr0 = wr_cnt;
        seen = 0;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F_B;
        req_addr_i = 32'h0100_0008; req_wdata_i = 32'h0000_00FF;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0; req_we_i = 1'b0;
        @(negedge clk);
        chk("rst mid in RD", 32'(mem_read_en_o), 32'd1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst mid ready", 32'(req_ready_o), 32'd0);
            chk("rst mid rd_en", 32'(mem_read_en_o), 32'd0);
            chk("rst mid rdata", rsp_rdata_o, 32'd0);
            if (rsp_valid_o === 1'b1 || mem_write_en_o === 1'b1) seen++;
        end
        rst = 1'b0;
        vld_en = 1'b1;
        @(negedge clk);
        chk("rst release ready", 32'(req_ready_o), 32'd1);
        repeat (4) begin
            if (rsp_valid_o === 1'b1 || mem_write_en_o === 1'b1) seen++;
            @(negedge clk);
        end
        chk("rst abort no rsp/write", 32'(seen), 32'd0);
        chk("rst abort write count", 32'(wr_cnt - wr0), 32'd0);
        do_req("LW post", 0, F_W, 32'h0100_0008, 0, 32'h1122_33AB, 0, 2, 1, -1, 0);

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that drives the byte-addressable `memory` block's read/write port on behalf of the datapath's memory stage. It accepts one load or store request at a time over a valid/ready handshake. It performs read-modify-write for sub-word stores, because the memory always writes four bytes. It sign- or zero-extends load data and returns a single-cycle response.

## Interface
- `AWIDTH`, 32, address width (matches memory)
- `DWIDTH`, 32, data width (fixed at 32; byte/half lane logic assumes it)
- `TIMEOUT`, 16, max cycles spent in RD waiting for `mem_data_vld_i` before erroring
- `clk` in 1: single clock, all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `req_valid_i` in 1: request present
- `req_ready_o` out 1: block can accept request
- `req_addr_i` in AWIDTH: byte address
- `req_wdata_i` in DWIDTH: store data, low-aligned
- `req_we_i` in 1: 1 = store, 0 = load
- `req_funct3_i` in 3: RV32I width/sign code
- `rsp_valid_o` out 1: one-cycle response pulse
- `rsp_rdata_o` out DWIDTH: extended load data; 0 for stores/errors
- `rsp_err_o` out 1: request failed; qualified by `rsp_valid_o`
- `mem_addr_o` out AWIDTH: to memory `addr_i`
- `mem_data_o` out DWIDTH: to memory `data_i`
- `mem_read_en_o` out 1: to memory `read_en_i`
- `mem_write_en_o` out 1: to memory `write_en_i`
- `mem_data_i` in DWIDTH: from memory `data_o`
- `mem_data_vld_i` in 1: from memory `data_vld_o`

## Operation
- FSM states: IDLE, RD, WR, RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch addr, wdata, we and funct3, then decode:
    - illegal funct3 → RESP with err;
    - load → RD;
    - SW → WR;
    - SB/SH → RD (read-modify-write).
- **Legal funct3**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- **RD**
  - Drive `mem_read_en_o`=1 and `mem_addr_o`=latched addr.
  - If `mem_data_vld_i`=1, capture `mem_data_i` as rbuf (wait counter clears on the transition):
    - load → RESP;
    - store → WR.
  - Otherwise increment the wait counter; on reaching `TIMEOUT`, go to RESP with err and no write.
- **Lane rules**
  - The memory returns bytes addr..addr+3 in [7:0]..[31:24], so no lane shifting is needed.
  - LB = {{24{d[7]}},d[7:0]}; LBU = {24'b0,d[7:0]}.
  - LH = {{16{d[15]}},d[15:0]}; LHU = {16'b0,d[15:0]}; LW = d.
- **WR**
  - Drive `mem_write_en_o`=1, `mem_addr_o`=latched addr, and `mem_data_o` as the merged word:
    - SB = {rbuf[31:8],wdata[7:0]};
    - SH = {rbuf[31:16],wdata[15:0]};
    - SW = wdata.
  - Exactly one cycle, then RESP.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle with `rsp_rdata_o`/`rsp_err_o`, then IDLE.
  - No response backpressure.
- **Output defaults**
  - `req_ready_o`=0 outside IDLE.
  - Memory enables are 0 outside RD/WR.
  - `mem_addr_o`/`mem_data_o` are 0 when their enable is low.

## Timing
- While `rst`=1: `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `mem_read_en_o` and `mem_write_en_o` are 0 and `rsp_rdata_o` is 0, regardless of state. The FSM, wait counter and latches clear.
- Reset mid-operation aborts the request: no write is issued in or after the reset cycle and no response is produced.
- Acceptance edge = T (cycle in IDLE with valid&ready).
  - Load with immediate `mem_data_vld_i`: RD at T+1, RESP at T+2.
  - SW: WR at T+1 (memory commits at the end of T+1), RESP at T+2.
  - SB/SH: RD T+1, WR T+2, RESP T+3.
  - Illegal/error decode: RESP T+1.
- Each RD wait cycle adds one cycle of latency. The timeout response is at T+1+`TIMEOUT`.
- Back-to-back requests: a new request can be accepted in the IDLE cycle directly following RESP. Minimum issue interval is 3 cycles for loads and SW.
- `rsp_rdata_o` and `rsp_err_o` are registered and hold their value until the next RESP. Only `rsp_valid_o` qualifies them.

## Configuration
- Macro: `LSU_ALIGN_CHECK_EN`.
- **Defined:** in IDLE, the following requests go to RESP with `rsp_err_o`=1 and issue no memory access:
  - LH/LHU/SH with addr[0]≠0;
  - LW/SW with addr[1:0]≠0.
- **Undefined:** misaligned requests are performed as-is, since the memory supports unaligned 4-byte access.

## Test plan
- Reset: hold `rst` 2 cycles mid-SB (in RD) → no `mem_write_en_o` pulse, no `rsp_valid_o`, `req_ready_o`=0 during reset and 1 in the first cycle after.
- Word at 0x01000004 = 0x12345680:
  - LB → `rsp_rdata_o`=0xFFFFFF80 at T+2;
  - LBU → 0x00000080;
  - LH → 0x00005680;
  - LW → 0x12345680.
- Word at 0x01000008 = 0x11223344:
  - SB wdata 0xDEADBEAB → `mem_data_o`=0x112233AB at T+2, RESP at T+3 with rdata 0;
  - then LW → 0x112233AB.
- SH 0x0000BEEF to 0x0100000C (word 0xAAAAAAAA) → write 0xAAAABEEF; SW 0xCAFEF00D → write at T+1, RESP at T+2.
- `mem_data_vld_i` forced 0 → `mem_read_en_o` high 16 cycles, RESP at T+17 with `rsp_err_o`=1, no write.
- Illegal funct3 3'b011 → RESP at T+1 with err=1 and no memory enable.
- LW at 0x01000002:
  - with `LSU_ALIGN_CHECK_EN` defined → err at T+1;
  - without it → data = bytes 2..5.
